// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns.
// The registered outputs show pixel (h_cnt,v_cnt) one clock after the counters hold it.
module vga_pattern_gen #(
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CHK_LOG2 = 5,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned H_W     = $clog2(H_TOTAL),
  localparam int unsigned V_W     = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hs,
  output logic                 vs,
  output logic                 blank,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic [H_W-1:0]       pix_x,
  output logic [V_W-1:0]       pix_y,
  output logic                 frame_start
);

  localparam int unsigned RGB_W    = 3 * COLOR_W;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int unsigned BP_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned XA_W     = $clog2(H_ACTIVE);
  localparam int unsigned YA_W     = $clog2(V_ACTIVE);

  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             h_last;
  logic             v_last;
  logic [BP_W-1:0]  bar_pos;
  logic [2:0]       bar_idx;
  logic [1:0]       mode_q;
  logic [RGB_W-1:0] solid_q;

  logic             active_c;
  logic             hs_c;
  logic             vs_c;
  logic [RGB_W-1:0] pat_c;

  assign h_last = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == V_W'(V_TOTAL - 1));

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // Bar index tracks min(h_cnt / BAR_W, 7) incrementally instead of dividing.
  always_ff @(posedge clk) begin
    if (reset || h_last) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BP_W'(BAR_W - 1)) begin
      bar_pos <= '0;
      if (bar_idx != 3'd7) begin
        bar_idx <= bar_idx + 3'd1;
      end
    end else begin
      bar_pos <= bar_pos + BP_W'(1);
    end
  end

  // Pattern controls are latched on the last pixel so a frame never changes mid-way.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      solid_q <= '0;
    end else if (h_last && v_last) begin
      mode_q  <= mode;
      solid_q <= solid_rgb;
    end
  end

  always_comb begin
    active_c = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
    hs_c     = (h_cnt >= H_W'(HS_START) && h_cnt <= H_W'(HS_END)) ? HS_POL : ~HS_POL;
    vs_c     = (v_cnt >= V_W'(VS_START) && v_cnt <= V_W'(VS_END)) ? VS_POL : ~VS_POL;
    pat_c    = '0;
    case (mode_q)
      2'd0:    pat_c = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
      2'd1:    pat_c = {RGB_W{h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]}};
      2'd2:    pat_c = {h_cnt[XA_W-1 -: COLOR_W], v_cnt[YA_W-1 -: COLOR_W], COLOR_W'(0)};
      default: pat_c = solid_q;
    endcase
    if (!active_c) begin
      pat_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank       <= 1'b1;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs_c;
      vs          <= vs_c;
      blank       <= ~active_c;
      {r, g, b}   <= pat_c;
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
